// File: rtl/line_rasterizer.sv
// Bresenham line walker: accepts one segment, then streams its on-screen pixels
// over valid/ready, stepping silently over points that fall outside the raster.
//
// state | meaning
// IDLE  | waiting for a segment; line_ready high
// SETUP | derive deltas, step directions and initial error from the captured segment
// DRAW  | one point per completion; off-screen points complete in a single cycle
// DONE  | one-cycle done pulse, then back to IDLE
module line_rasterizer #(
   parameter int COORD_W  = 13,
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               line_valid,
   output logic               line_ready,
   input  logic [COORD_W-1:0] DStartX,
   input  logic [COORD_W-1:0] DEndX,
   input  logic [COORD_W-1:0] DStartY,
   input  logic [COORD_W-1:0] DEndY,
   input  logic [3:0]         DIntensity,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic [COORD_W-1:0] pix_x,
   output logic [COORD_W-1:0] pix_y,
   output logic [3:0]         pix_intensity,
   output logic               busy,
   output logic               done
);
   localparam int DW = COORD_W + 2;
   localparam int EW = COORD_W + 3;
   localparam logic [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_W);
   localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_H);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [COORD_W-1:0] x1_q, x1_d, y1_q, y1_d;
   logic [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
   logic [DW-1:0]      dx_q, dx_d, dy_q, dy_d, err_q, err_d;
   logic               sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
   logic               pix_valid_q, pix_valid_d;
   logic [COORD_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic [3:0]         pix_int_q, pix_int_d;
   logic               busy_q, busy_d, done_q, done_d, line_ready_q, line_ready_d;

   logic signed [DW-1:0] diff_x, diff_y, abs_x, abs_y;
   logic signed [EW-1:0] e2;
   logic                 step_x, step_y, at_end, point_done;
   logic [COORD_W-1:0]   inc_x, inc_y, nx, ny;
   logic [DW-1:0]        err_step;

   // Sign bit first: a negative coordinate never passes the unsigned limit compare.
   function automatic logic on_screen(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
      return !x[COORD_W-1] && !y[COORD_W-1] && (x < X_LIM) && (y < Y_LIM);
   endfunction

   always_comb begin
      diff_x = $signed({{2{x1_q[COORD_W-1]}}, x1_q}) - $signed({{2{cur_x_q[COORD_W-1]}}, cur_x_q});
      diff_y = $signed({{2{y1_q[COORD_W-1]}}, y1_q}) - $signed({{2{cur_y_q[COORD_W-1]}}, cur_y_q});
      abs_x  = diff_x[DW-1] ? -diff_x : diff_x;
      abs_y  = diff_y[DW-1] ? -diff_y : diff_y;

      e2       = $signed({err_q, 1'b0});
      step_x   = e2 >= $signed({dy_q[DW-1], dy_q});
      step_y   = e2 <= $signed({dx_q[DW-1], dx_q});
      err_step = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
      inc_x    = sx_neg_q ? {COORD_W{1'b1}} : COORD_W'(1);
      inc_y    = sy_neg_q ? {COORD_W{1'b1}} : COORD_W'(1);
      nx       = step_x ? cur_x_q + inc_x : cur_x_q;
      ny       = step_y ? cur_y_q + inc_y : cur_y_q;
      at_end     = (cur_x_q == x1_q) && (cur_y_q == y1_q);
      point_done = !pix_valid_q || pix_ready;

      state_d     = state_q;
      x1_d        = x1_q;
      y1_d        = y1_q;
      cur_x_d     = cur_x_q;
      cur_y_d     = cur_y_q;
      dx_d        = dx_q;
      dy_d        = dy_q;
      err_d       = err_q;
      sx_neg_d    = sx_neg_q;
      sy_neg_d    = sy_neg_q;
      pix_valid_d = pix_valid_q;
      pix_x_d     = pix_x_q;
      pix_y_d     = pix_y_q;
      pix_int_d   = pix_int_q;
      done_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (line_valid && line_ready_q) begin
               cur_x_d   = DStartX;
               cur_y_d   = DStartY;
               x1_d      = DEndX;
               y1_d      = DEndY;
               pix_int_d = DIntensity;
               state_d   = S_SETUP;
            end
         end
         S_SETUP: begin
            dx_d        = abs_x;
            dy_d        = -abs_y;
            err_d       = abs_x - abs_y;
            sx_neg_d    = diff_x[DW-1];
            sy_neg_d    = diff_y[DW-1];
            pix_valid_d = on_screen(cur_x_q, cur_y_q);
            if (on_screen(cur_x_q, cur_y_q)) begin
               pix_x_d = cur_x_q;
               pix_y_d = cur_y_q;
            end
            state_d = S_DRAW;
         end
         S_DRAW: begin
            if (point_done) begin
               if (at_end) begin
                  pix_valid_d = 1'b0;
                  done_d      = 1'b1;
                  state_d     = S_DONE;
               end else begin
                  cur_x_d     = nx;
                  cur_y_d     = ny;
                  err_d       = err_step;
                  pix_valid_d = on_screen(nx, ny);
                  if (on_screen(nx, ny)) begin
                     pix_x_d = nx;
                     pix_y_d = ny;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d       = (state_d != S_IDLE);
      line_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         x1_q         <= '0;
         y1_q         <= '0;
         cur_x_q      <= '0;
         cur_y_q      <= '0;
         dx_q         <= '0;
         dy_q         <= '0;
         err_q        <= '0;
         sx_neg_q     <= 1'b0;
         sy_neg_q     <= 1'b0;
         pix_valid_q  <= 1'b0;
         pix_x_q      <= '0;
         pix_y_q      <= '0;
         pix_int_q    <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         line_ready_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         x1_q         <= x1_d;
         y1_q         <= y1_d;
         cur_x_q      <= cur_x_d;
         cur_y_q      <= cur_y_d;
         dx_q         <= dx_d;
         dy_q         <= dy_d;
         err_q        <= err_d;
         sx_neg_q     <= sx_neg_d;
         sy_neg_q     <= sy_neg_d;
         pix_valid_q  <= pix_valid_d;
         pix_x_q      <= pix_x_d;
         pix_y_q      <= pix_y_d;
         pix_int_q    <= pix_int_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         line_ready_q <= line_ready_d;
      end
   end

   assign line_ready    = line_ready_q;
   assign pix_valid     = pix_valid_q;
   assign pix_x         = pix_x_q;
   assign pix_y         = pix_y_q;
   assign pix_intensity = pix_int_q;
   assign busy          = busy_q;
   assign done          = done_q;
endmodule

// File: tb/tb_line_rasterizer.sv
// Directed bench for line_rasterizer: table of segments with hand-derived pixel
// sequences, plus hand-written reset-during-draw sequence.
module tb_line_rasterizer;
   localparam int CW = 13;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          line_valid = 1'b0;
   logic          pix_ready = 1'b1;
   logic [CW-1:0] DStartX = '0, DEndX = '0, DStartY = '0, DEndY = '0;
   logic [3:0]    DIntensity = '0;
   logic          line_ready, pix_valid, busy, done;
   logic [CW-1:0] pix_x, pix_y;
   logic [3:0]    pix_intensity;

   int n_pass = 0;
   int n_total = 0;

   line_rasterizer #(.COORD_W(CW), .SCREEN_W(640), .SCREEN_H(480)) dut (
      .clk(clk), .rst(rst),
      .line_valid(line_valid), .line_ready(line_ready),
      .DStartX(DStartX), .DEndX(DEndX), .DStartY(DStartY), .DEndY(DEndY),
      .DIntensity(DIntensity),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_x(pix_x), .pix_y(pix_y), .pix_intensity(pix_intensity),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Cycle numbers count negedges after the accepting posedge: 1 = SETUP, 2 = first DRAW.
   // stall_lo..stall_hi: cycles with pix_ready low; inj_cyc: cycle with a stray line_valid.
   typedef struct {
      int x0, y0, x1, y1;
      int inten;
      int nexp;
      int first_cyc;
      int done_cyc;
      int stall_lo, stall_hi;
      int inj_cyc;
      int px[6];
      int py[6];
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic run_seg(input vec_t v);
      int got, first, done_c, w;
      got = 0; first = -1; done_c = -1; w = 0;
      while (!line_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("line_ready_idle", int'(line_ready), 1);
      DStartX    = CW'(v.x0);
      DStartY    = CW'(v.y0);
      DEndX      = CW'(v.x1);
      DEndY      = CW'(v.y1);
      DIntensity = 4'(v.inten);
      line_valid = 1'b1;
      pix_ready  = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         line_valid = (c == v.inj_cyc);
         if (c == v.inj_cyc) begin
            DStartX = CW'(50); DStartY = CW'(50); DEndX = CW'(60); DEndY = CW'(60);
            check("line_ready_while_busy", int'(line_ready), 0);
         end
         if (c == 1) begin
            check("setup_busy", int'(busy), 1);
            check("setup_pix_valid", int'(pix_valid), 0);
         end
         pix_ready = !(c >= v.stall_lo && c <= v.stall_hi);
         if (pix_valid) begin
            if (first < 0) first = c;
            if (got < v.nexp) begin
               check("pix_x", int'(pix_x), v.px[got]);
               check("pix_y", int'(pix_y), v.py[got]);
               check("pix_intensity", int'(pix_intensity), v.inten);
            end else begin
               check("pix_extra", got + 1, v.nexp);
            end
            if (pix_ready) got++;
         end
         if (done) begin
            done_c = c;
            break;
         end
      end
      line_valid = 1'b0;
      pix_ready  = 1'b1;
      check("pix_count", got, v.nexp);
      check("first_pix_cycle", first, v.first_cyc);
      check("done_cycle", done_c, v.done_cyc);
      @(negedge clk);
      check("done_pulse_width", int'(done), 0);
      check("idle_line_ready", int'(line_ready), 1);
      check("idle_busy", int'(busy), 0);
      @(negedge clk);
      check("no_queued_segment", int'(busy), 0);
   endtask

   initial begin
      vecs[0] = '{0, 0, 3, 0, 7, 4, 2, 6, 0, -1, 0, '{0, 1, 2, 3, 0, 0}, '{0, 0, 0, 0, 0, 0}};
      vecs[1] = '{5, 1, 6, 4, 3, 4, 2, 6, 0, -1, 0, '{5, 5, 6, 6, 0, 0}, '{1, 2, 3, 4, 0, 0}};
      vecs[2] = '{3, 2, 0, 2, 12, 4, 2, 6, 0, -1, 0, '{3, 2, 1, 0, 0, 0}, '{2, 2, 2, 2, 0, 0}};
      vecs[3] = '{9, 9, 9, 9, 1, 1, 2, 3, 0, -1, 0, '{9, 0, 0, 0, 0, 0}, '{9, 0, 0, 0, 0, 0}};
      // pix_ready low over the two clipped points must not delay them
      vecs[4] = '{-2, 0, 1, 0, 5, 2, 4, 6, 2, 3, 0, '{0, 1, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0}};
      vecs[5] = '{700, 10, 705, 10, 9, 0, -1, 8, 0, -1, 0, '{0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0}};
      vecs[6] = '{0, 0, 4, 2, 15, 5, 2, 7, 0, -1, 0, '{0, 1, 2, 3, 4, 0}, '{0, 1, 1, 2, 2, 0}};
      vecs[7] = '{638, 479, 641, 481, 2, 1, 2, 6, 0, -1, 0, '{638, 0, 0, 0, 0, 0}, '{479, 0, 0, 0, 0, 0}};
      vecs[8] = '{2, 3, 2, 0, 6, 4, 2, 6, 0, -1, 0, '{2, 2, 2, 2, 0, 0}, '{3, 2, 1, 0, 0, 0}};
      // second pixel stalled three cycles, stray line_valid mid-segment
      vecs[9] = '{0, 0, 2, 2, 4, 3, 2, 8, 3, 5, 4, '{0, 1, 2, 0, 0, 0}, '{0, 1, 2, 0, 0, 0}};

      @(negedge clk);
      check("rst_pix_valid", int'(pix_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_pix_x", int'(pix_x), 0);
      check("rst_pix_y", int'(pix_y), 0);
      check("rst_pix_intensity", int'(pix_intensity), 0);
      rst = 1'b1;
      check("release_line_ready", int'(line_ready), 0);
      @(negedge clk);
      check("post_release_line_ready", int'(line_ready), 1);

      for (int i = 0; i < 10; i++) run_seg(vecs[i]);

      // Reset pulled during DRAW of (0,0)->(10,0) with (3,0) on the bus
      DStartX = CW'(0); DStartY = CW'(0); DEndX = CW'(10); DEndY = CW'(0);
      DIntensity = 4'd8;
      line_valid = 1'b1;
      pix_ready  = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         line_valid = 1'b0;
      end
      check("pre_reset_pix_valid", int'(pix_valid), 1);
      check("pre_reset_pix_x", int'(pix_x), 3);
      #2 rst = 1'b0;
      #1;
      check("async_rst_pix_valid", int'(pix_valid), 0);
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_pix_x", int'(pix_x), 0);
      check("async_rst_line_ready", int'(line_ready), 0);
      @(negedge clk);
      @(negedge clk);
      check("held_rst_pix_valid", int'(pix_valid), 0);
      rst = 1'b1;
      @(negedge clk);
      check("rerelease_line_ready", int'(line_ready), 1);
      check("rerelease_pix_valid", int'(pix_valid), 0);
      run_seg(vecs[1]);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
